regbank_sb: RTL and testbench
=============================

# regbank_sb

Parametrised general-purpose register bank for the processor datapath, with a per-register pending-write scoreboard. It provides two combinational read ports and one clocked write port. Width, register count, stack-pointer index and its reset value are configurable. The scoreboard lets the issue stage detect read-after-write hazards against in-flight writes. It replaces the fixed 4-bit, 20-entry bank in the decode/writeback path.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of architectural registers (2..256)
- ADDR_W, $clog2(NUM_REGS), register address width
- SP_INDEX, 13, index of the stack-pointer register
- STACK_POINTER, 32'h00000AF0, reset value of register SP_INDEX (truncated to DATA_W)
- ZERO_REG, 0, when 1 register 0 reads as zero and ignores writes and issue marks
- CLK  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- WriteRegister  input  1  write enable (writeback)
- WriteRegisterAddress  input  ADDR_W  write destination
- WriteData  input  DATA_W  write data
- ReadRegister1 / ReadRegister2  input  ADDR_W  read sources
- ReadData1 / ReadData2  output  DATA_W  read operands
- IssueValid  input  1  an instruction writing IssueRegister is issued this cycle
- IssueRegister  input  ADDR_W  destination of the issued instruction
- Pending1 / Pending2  output  1  source register has an outstanding write
- PendingAny  output  1  OR of all pending bits

## Operation
- Storage: NUM_REGS x DATA_W flops and a NUM_REGS-bit pending vector.
- Reset (asynchronous, immediate):
  - All registers clear to 0, except SP_INDEX, which loads STACK_POINTER.
  - All pending bits clear to 0.
  - With all-zero read addresses, outputs are ReadData1/2=0 (or STACK_POINTER if SP_INDEX=0), Pending1/2=0 and PendingAny=0.
- Reset mid-operation aborts everything: in-flight writes are lost and the scoreboard clears.
- Write: on a rising edge with WriteRegister=1 and address < NUM_REGS, the register loads WriteData. The write is ignored for address >= NUM_REGS, or for address 0 when ZERO_REG=1.
- Read: ReadDataN = reg[ReadRegisterN], combinational. An address >= NUM_REGS reads as 0. Address 0 reads as 0 when ZERO_REG=1.
- Scoreboard update on a rising edge, in this priority order:
  - A write clears pending[WriteRegisterAddress].
  - An issue sets pending[IssueRegister].
  - If write and issue target the same register in the same cycle, the bit ends set, because the new producer wins.
  - Out-of-range addresses and register 0 (when ZERO_REG=1) never become pending.
- PendingN = pending[ReadRegisterN]. It is 0 for out-of-range addresses and for ZERO_REG-masked register 0.
- Writes without a prior issue are legal and leave the pending bit clear.
- A repeated issue to an already-pending register keeps the bit set; there is no count.

## Timing
- Read latency is 0 cycles, combinational from the address.
- Without bypass, write-to-read latency is 1 cycle: the new value is visible after the edge.
- Scoreboard latency is 1 cycle: a bit set or cleared at edge N is reflected on PendingN after edge N.
- No handshake back-pressure. The issue stage must stall itself while Pending1 or Pending2 is high for a used operand.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-to-read forwarding is enabled. If WriteRegister=1 and WriteRegisterAddress == ReadRegisterN, with a valid and unmasked address, ReadDataN = WriteData in the same cycle.
  - In that case PendingN is forced to 0 in that cycle.
- Without the macro: reads always return stored state, and PendingN reflects the stored bit only.

## Test plan
- Reset with SP_INDEX=13, STACK_POINTER=32'h00000AF0 -> ReadRegister1=13 gives ReadData1=32'h00000AF0, ReadRegister2=5 gives 0; PendingAny=0.
- Write 32'hDEADBEEF to r3, then read r3 on both ports next cycle -> both ports read 32'hDEADBEEF. With REGFILE_BYPASS_EN, the value is already visible in the write cycle.
- ZERO_REG=1: write 32'h12345678 to r0 and issue r0 -> ReadData1=0 and Pending1=0. Write to address 16 when NUM_REGS=16 -> no register changes, and a read of 16 returns 0.
- Issue r7, read r7 next cycle -> Pending1=1, PendingAny=1. Write r7=32'h55 two cycles later -> Pending1=0 after the edge and ReadData1=32'h55.
- Same-edge write r4 and issue r4 -> after the edge pending[4]=1 and r4 holds the written data.
- Issue r2 and r9, then assert Reset asynchronously between edges -> PendingAny=0 immediately and r2=0. r13 returns to 32'h00000AF0 without a clock edge.

Source files
------------

// File: rtl/regbank_sb.sv
// rtl/regbank_sb.sv - parametrised register bank with two read ports, one write port and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regbank_sb #(
    parameter int          DATA_W        = 32,
    parameter int          NUM_REGS      = 16,
    parameter int          ADDR_W        = $clog2(NUM_REGS),
    parameter int          SP_INDEX      = 13,
    parameter logic [31:0] STACK_POINTER = 32'h00000AF0,
    parameter bit          ZERO_REG      = 1'b0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              WriteRegister,
    input  logic [ADDR_W-1:0] WriteRegisterAddress,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueRegister,
    output logic              Pending1,
    output logic              Pending2,
    output logic              PendingAny
);

    localparam logic [DATA_W-1:0] SP_RESET = DATA_W'(STACK_POINTER);

    logic [DATA_W-1:0]   regFile [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pendingNext;
    logic [NUM_REGS-1:0] writeHit;
    logic [NUM_REGS-1:0] issueHit;

    // Register 0 is hard-wired to zero when ZERO_REG is set.
    function automatic logic usable(input int idx);
        return !(ZERO_REG && (idx == 0));
    endfunction

    // Address decode doubles as the range check: out-of-range addresses hit nothing.
    always_comb begin
        writeHit = '0;
        issueHit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            writeHit[i] = WriteRegister && (WriteRegisterAddress == ADDR_W'(i)) && usable(i);
            issueHit[i] = IssueValid && (IssueRegister == ADDR_W'(i)) && usable(i);
        end
    end

    // Issue is applied after the write clear so a new producer keeps the bit set.
    assign pendingNext = (pending & ~writeHit) | issueHit;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (writeHit[i]) begin
                    regFile[i] <= WriteData;
                end
            end
            pending <= pendingNext;
        end
    end

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        Pending1  = 1'b0;
        Pending2  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (usable(i) && (ReadRegister1 == ADDR_W'(i))) begin
                ReadData1 = regFile[i];
                Pending1  = pending[i];
            end
            if (usable(i) && (ReadRegister2 == ADDR_W'(i))) begin
                ReadData2 = regFile[i];
                Pending2  = pending[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        // A forwarded operand is by definition no longer outstanding.
        if ((|writeHit) && (WriteRegisterAddress == ReadRegister1)) begin
            ReadData1 = WriteData;
            Pending1  = 1'b0;
        end
        if ((|writeHit) && (WriteRegisterAddress == ReadRegister2)) begin
            ReadData2 = WriteData;
            Pending2  = 1'b0;
        end
`else
`endif
    end

    assign PendingAny = |pending;

endmodule

// File: tb/tb_regbank_sb.sv
// tb/tb_regbank_sb.sv - table-driven self-checking bench for regbank_sb.
module tb_regbank_sb;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        WriteRegister = 1'b0;
    logic [4:0]  WriteRegisterAddress = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic        IssueValid = 1'b0;
    logic [4:0]  IssueRegister = '0;

    logic [31:0] rdA1, rdA2, rdB1, rdB2;
    logic        pA1, pA2, pAnyA, pB1, pB2, pAnyB;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Instance A: zero register enabled, address widened so address 16 is expressible.
    regbank_sb #(.NUM_REGS(16), .ADDR_W(5), .ZERO_REG(1'b1)) dutA (
        .CLK(CLK), .Reset(Reset),
        .WriteRegister(WriteRegister), .WriteRegisterAddress(WriteRegisterAddress),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rdA1), .ReadData2(rdA2),
        .IssueValid(IssueValid), .IssueRegister(IssueRegister),
        .Pending1(pA1), .Pending2(pA2), .PendingAny(pAnyA)
    );

    // Instance B: default parameters, register 0 is an ordinary register.
    regbank_sb dutB (
        .CLK(CLK), .Reset(Reset),
        .WriteRegister(WriteRegister), .WriteRegisterAddress(WriteRegisterAddress[3:0]),
        .WriteData(WriteData),
        .ReadRegister1(ReadRegister1[3:0]), .ReadRegister2(ReadRegister2[3:0]),
        .ReadData1(rdB1), .ReadData2(rdB2),
        .IssueValid(IssueValid), .IssueRegister(IssueRegister[3:0]),
        .Pending1(pB1), .Pending2(pB2), .PendingAny(pAnyB)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        iv;
        logic [4:0]  ireg;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        expP1;
        logic        expP2;
        logic        expAny;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic edgeAndIdle();
        @(posedge CLK);
        #1;
        WriteRegister = 1'b0;
        IssueValid    = 1'b0;
        #1;
    endtask

    initial begin
        // Each row: drive write/issue for one edge, then read with write/issue idle.
        vecs[0]  = '{1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  5'd0,  5'd3,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd16, 32'hAAAAAAAA, 1'b0, 5'd0,  5'd16, 5'd3,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd3,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0,  5'd7,  5'd13, 32'h00000055, 32'h00000AF0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd4,  32'h00001234, 1'b1, 5'd4,  5'd4,  5'd7,  32'h00001234, 32'h00000055, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 5'd4,  32'h00004321, 1'b0, 5'd0,  5'd4,  5'd4,  32'h00004321, 32'h00004321, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 5'd15, 5'd16, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 5'd15, 5'd15, 32'h0,        32'h0,        1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 5'd15, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd15, 5'd0,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd16, 5'd16, 5'd15, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd0,  5'd12, 5'd3,  32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};

        ReadRegister1 = 5'd13;
        ReadRegister2 = 5'd5;
        #12;
        check("reset_sp_rd1", rdA1, 32'h00000AF0);
        check("reset_r5_rd2", rdA2, 32'h0);
        check("reset_pany",   {31'b0, pAnyA}, 32'h0);
        check("reset_p1",     {31'b0, pA1}, 32'h0);
        check("resetB_sp",    rdB1, 32'h00000AF0);

        @(posedge CLK);
        #1;
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            WriteRegister        = vecs[i].we;
            WriteRegisterAddress = vecs[i].waddr;
            WriteData            = vecs[i].wdata;
            IssueValid           = vecs[i].iv;
            IssueRegister        = vecs[i].ireg;
            ReadRegister1        = vecs[i].r1;
            ReadRegister2        = vecs[i].r2;
            edgeAndIdle();
            check($sformatf("v%0d_rd1", i), rdA1, vecs[i].exp1);
            check($sformatf("v%0d_rd2", i), rdA2, vecs[i].exp2);
            check($sformatf("v%0d_p1", i),  {31'b0, pA1},   {31'b0, vecs[i].expP1});
            check($sformatf("v%0d_p2", i),  {31'b0, pA2},   {31'b0, vecs[i].expP2});
            check($sformatf("v%0d_pany", i), {31'b0, pAnyA}, {31'b0, vecs[i].expAny});
            if (i == 1) begin
                check("B_r0_written", rdB1, 32'h12345678);
                check("B_r0_pending", {31'b0, pB1}, 32'h1);
            end
        end

        // Write-cycle visibility of a pending register.
        IssueValid    = 1'b1;
        IssueRegister = 5'd3;
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd13;
        edgeAndIdle();
        check("byp_pre_p1", {31'b0, pA1}, 32'h1);
        WriteRegister        = 1'b1;
        WriteRegisterAddress = 5'd3;
        WriteData            = 32'h0BADF00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_rd1", rdA1, 32'h0BADF00D);
        check("byp_same_p1",  {31'b0, pA1}, 32'h0);
`else
        check("byp_same_rd1", rdA1, 32'hDEADBEEF);
        check("byp_same_p1",  {31'b0, pA1}, 32'h1);
`endif
        check("byp_same_rd2", rdA2, 32'h00000AF0);
        edgeAndIdle();
        check("byp_after_rd1", rdA1, 32'h0BADF00D);
        check("byp_after_p1",  {31'b0, pA1}, 32'h0);

        // Asynchronous reset between edges wipes data and scoreboard.
        WriteRegister        = 1'b1;
        WriteRegisterAddress = 5'd2;
        WriteData            = 32'h00000022;
        IssueValid           = 1'b1;
        IssueRegister        = 5'd2;
        edgeAndIdle();
        WriteRegister        = 1'b1;
        WriteRegisterAddress = 5'd13;
        WriteData            = 32'h00001111;
        IssueValid           = 1'b1;
        IssueRegister        = 5'd9;
        ReadRegister1        = 5'd2;
        ReadRegister2        = 5'd13;
        edgeAndIdle();
        check("pre_rst_r2",   rdA1, 32'h00000022);
        check("pre_rst_p2",   {31'b0, pA1}, 32'h1);
        check("pre_rst_r13",  rdA2, 32'h00001111);
        check("pre_rst_pany", {31'b0, pAnyA}, 32'h1);
        #1;
        Reset = 1'b1;
        #1;
        check("rst_r2",    rdA1, 32'h0);
        check("rst_r13",   rdA2, 32'h00000AF0);
        check("rst_pany",  {31'b0, pAnyA}, 32'h0);
        check("rst_panyB", {31'b0, pAnyB}, 32'h0);
        ReadRegister1 = 5'd9;
        #1;
        check("rst_p9", {31'b0, pA1}, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #2;
        check("post_rst_r13", rdA2, 32'h00000AF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
